// File: rtl/sme_param.sv
// ---------------------------------------------------------------------------
// sme_param - parametrised string-matching engine
//
// Stores one string frame (isstring high), then evaluates each following
// pattern frame (ispattern high) against it. Pattern elements: literal,
// '.' (any char), '^' (word start), '$' (word end), one '*' (non-greedy run).
// The result is the leftmost match: start index and consumed length.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   chardata     character of the current string/pattern frame
//   isstring     chardata belongs to a string frame
//   ispattern    chardata belongs to a pattern frame
//   ignore_case  sampled with the first pattern char; folds ASCII A-Z/a-z
//   busy         high while a search is running
//   valid        one-cycle result strobe
//   match        pattern found
//   match_index  start position of the leftmost match
//   match_len    string characters consumed by that match
// ---------------------------------------------------------------------------
module sme_param #(
  parameter int DW      = 8,
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int IW      = $clog2(STR_MAX),
  parameter int LW      = $clog2(STR_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] chardata,
  input  logic          isstring,
  input  logic          ispattern,
  input  logic          ignore_case,
  output logic          busy,
  output logic          valid,
  output logic          match,
  output logic [IW-1:0] match_index,
  output logic [LW-1:0] match_len
);

  localparam int PW  = $clog2(PAT_MAX + 1);
  localparam int PIW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

  localparam logic [DW-1:0] CH_DOT    = DW'(8'h2E);
  localparam logic [DW-1:0] CH_CARET  = DW'(8'h5E);
  localparam logic [DW-1:0] CH_DOLLAR = DW'(8'h24);
  localparam logic [DW-1:0] CH_STAR   = DW'(8'h2A);
  localparam logic [DW-1:0] CH_SPACE  = DW'(8'h20);
  localparam logic [DW-1:0] CH_UA     = DW'(8'h41);
  localparam logic [DW-1:0] CH_UZ     = DW'(8'h5A);
  localparam logic [DW-1:0] CH_CASE   = DW'(8'h20);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_STR, ST_LOAD_PAT, ST_SEARCH, ST_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [LW-1:0] str_len_reg, str_len_next;
  logic [PW-1:0] pat_len_reg, pat_len_next;
  logic          icase_reg, icase_next;
  // Search cursor: candidate start, string position, pattern index.
  logic [LW-1:0] s_reg, s_next;
  logic [LW-1:0] pos_reg, pos_next;
  logic [PW-1:0] pi_reg, pi_next;
  // Star bookkeeping: suffix start index and where the current span ends.
  logic          star_reg, star_next;
  logic [PW-1:0] star_pi_reg, star_pi_next;
  logic [LW-1:0] star_pos_reg, star_pos_next;
  logic          match_reg, match_next;
  logic [IW-1:0] index_reg, index_next;
  logic [LW-1:0] len_reg, len_next;

  // Character storage (no reset: lengths alone define valid contents).
  logic [DW-1:0]  str_mem [STR_MAX];
  logic [DW-1:0]  pat_mem [PAT_MAX];
  logic           str_we, pat_we;
  logic [IW-1:0]  str_waddr;
  logic [PIW-1:0] pat_waddr;

  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_waddr] <= chardata;
    if (pat_we) pat_mem[pat_waddr] <= chardata;
  end

  function automatic logic [DW-1:0] fold(input logic [DW-1:0] c);
    if (c >= CH_UA && c <= CH_UZ) return c + CH_CASE;
    return c;
  endfunction

  // Current element evaluation
  logic [DW-1:0] pat_ch, str_ch, str_prev;
  logic          at_end, chars_equal, elem_ok, elem_adv;
  logic [LW-1:0] pos_after;
  logic [PW-1:0] pi_inc;

  assign pat_ch   = pat_mem[pi_reg[PIW-1:0]];
  assign str_ch   = str_mem[pos_reg[IW-1:0]];
  assign str_prev = str_mem[pos_reg[IW-1:0] - IW'(1)];
  assign at_end   = (pos_reg == str_len_reg);
  assign chars_equal = icase_reg ? (fold(pat_ch) == fold(str_ch)) : (pat_ch == str_ch);

  // Reads past the string end return stale data; every use is guarded by
  // at_end / pos==0 so they never influence the result.
  always_comb begin
    elem_ok  = 1'b0;
    elem_adv = 1'b0;
    if (pat_ch == CH_STAR) begin
      elem_ok = 1'b1;
    end else if (pat_ch == CH_CARET) begin
      elem_ok = (pos_reg == '0) || (str_prev == CH_SPACE);
    end else if (pat_ch == CH_DOLLAR) begin
      elem_ok = at_end || (str_ch == CH_SPACE);
    end else begin
      elem_adv = 1'b1;
      elem_ok  = !at_end && ((pat_ch == CH_DOT) || chars_equal);
    end
  end

  assign pos_after = pos_reg + LW'(elem_adv);
  assign pi_inc    = pi_reg + PW'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      str_len_reg  <= '0;
      pat_len_reg  <= '0;
      icase_reg    <= 1'b0;
      s_reg        <= '0;
      pos_reg      <= '0;
      pi_reg       <= '0;
      star_reg     <= 1'b0;
      star_pi_reg  <= '0;
      star_pos_reg <= '0;
      match_reg    <= 1'b0;
      index_reg    <= '0;
      len_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      str_len_reg  <= str_len_next;
      pat_len_reg  <= pat_len_next;
      icase_reg    <= icase_next;
      s_reg        <= s_next;
      pos_reg      <= pos_next;
      pi_reg       <= pi_next;
      star_reg     <= star_next;
      star_pi_reg  <= star_pi_next;
      star_pos_reg <= star_pos_next;
      match_reg    <= match_next;
      index_reg    <= index_next;
      len_reg      <= len_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    str_len_next  = str_len_reg;
    pat_len_next  = pat_len_reg;
    icase_next    = icase_reg;
    s_next        = s_reg;
    pos_next      = pos_reg;
    pi_next       = pi_reg;
    star_next     = star_reg;
    star_pi_next  = star_pi_reg;
    star_pos_next = star_pos_reg;
    match_next    = match_reg;
    index_next    = index_reg;
    len_next      = len_reg;
    str_we        = 1'b0;
    pat_we        = 1'b0;
    str_waddr     = str_len_reg[IW-1:0];
    pat_waddr     = pat_len_reg[PIW-1:0];

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (isstring) begin
          state_next   = ST_LOAD_STR;
          str_we       = 1'b1;
          str_waddr    = '0;
          str_len_next = LW'(1);
        end else if (ispattern) begin
          state_next   = ST_LOAD_PAT;
          pat_we       = 1'b1;
          pat_waddr    = '0;
          pat_len_next = PW'(1);
          icase_next   = ignore_case;
        end
      end

      ST_LOAD_STR: begin
        if (isstring) begin
          if (str_len_reg < LW'(STR_MAX)) begin
            str_we       = 1'b1;
            str_len_next = str_len_reg + LW'(1);
          end
        end else if (ispattern) begin
          state_next   = ST_LOAD_PAT;
          pat_we       = 1'b1;
          pat_waddr    = '0;
          pat_len_next = PW'(1);
          icase_next   = ignore_case;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_LOAD_PAT: begin
        if (ispattern && !isstring) begin
          if (pat_len_reg < PW'(PAT_MAX)) begin
            pat_we       = 1'b1;
            pat_len_next = pat_len_reg + PW'(1);
          end
        end else begin
          state_next = ST_SEARCH;
          s_next     = '0;
          pos_next   = '0;
          pi_next    = '0;
          star_next  = 1'b0;
        end
      end

      ST_SEARCH: begin
        if (str_len_reg == '0 || pat_len_reg == '0) begin
          state_next = ST_DONE;
          match_next = 1'b0;
          index_next = '0;
          len_next   = '0;
        end else if (elem_ok) begin
          if (pi_inc == pat_len_reg) begin
            state_next = ST_DONE;
            match_next = 1'b1;
            index_next = s_reg[IW-1:0];
            len_next   = pos_after - s_reg;
          end else begin
            pi_next  = pi_inc;
            pos_next = pos_after;
            if (pat_ch == CH_STAR) begin
              star_next     = 1'b1;
              star_pi_next  = pi_inc;
              star_pos_next = pos_reg;
            end
          end
        end else if (star_reg && (star_pos_reg != str_len_reg)) begin
          // Grow the star span by one and retry the suffix after it.
          star_pos_next = star_pos_reg + LW'(1);
          pos_next      = star_pos_reg + LW'(1);
          pi_next       = star_pi_reg;
        end else if (s_reg != str_len_reg) begin
          s_next    = s_reg + LW'(1);
          pos_next  = s_reg + LW'(1);
          pi_next   = '0;
          star_next = 1'b0;
        end else begin
          state_next = ST_DONE;
          match_next = 1'b0;
          index_next = '0;
          len_next   = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state_reg == ST_SEARCH);
  assign valid       = (state_reg == ST_DONE);
  assign match       = match_reg;
  assign match_index = index_reg;
  assign match_len   = len_reg;

endmodule

// File: tb/tb_sme_param.sv
module tb_sme_param;
  localparam int DW      = 8;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IW      = 5;
  localparam int LW      = 6;
  localparam int MAX_WAIT = 12000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] chardata = '0;
  logic          isstring = 1'b0;
  logic          ispattern = 1'b0;
  logic          ignore_case = 1'b0;
  logic          busy, valid, match;
  logic [IW-1:0] match_index;
  logic [LW-1:0] match_len;

  int checks = 0;
  int failures = 0;
  int txn = 0;

  sme_param #(.DW(DW), .STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .ignore_case(ignore_case), .busy(busy),
    .valid(valid), .match(match), .match_index(match_index), .match_len(match_len)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string str;   // empty: keep the stored string
    string pat;
    bit    ic;
    bit    em;
    int    ei;
    int    el;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (search semantics, not cycles) --------
  function automatic byte lower(input byte c);
    if (c >= 8'h41 && c <= 8'h5A) return c + 8'd32;
    return c;
  endfunction

  // Match pattern elements [pfrom, pto) starting at string position pos_in.
  function automatic bit match_seq(input string st, input string pt, input int pfrom,
                                   input int pto, input int pos_in, input bit ic,
                                   output int pos_out);
    int  pos;
    byte e;
    pos = pos_in;
    pos_out = pos_in;
    for (int k = pfrom; k < pto; k++) begin
      e = pt[k];
      if (e == 8'h5E) begin
        if (!(pos == 0 || st[pos-1] == 8'h20)) return 1'b0;
      end else if (e == 8'h24) begin
        if (!(pos == st.len() || st[pos] == 8'h20)) return 1'b0;
      end else begin
        if (pos >= st.len()) return 1'b0;
        if (e != 8'h2E) begin
          if (ic ? (lower(e) != lower(st[pos])) : (e != st[pos])) return 1'b0;
        end
        pos++;
      end
    end
    pos_out = pos;
    return 1'b1;
  endfunction

  function automatic void model(input string st_in, input string pt_in, input bit ic,
                                output bit m, output int idx, output int ln);
    string st, pt;
    int star, p, pe;
    m = 1'b0; idx = 0; ln = 0;
    if (st_in.len() == 0 || pt_in.len() == 0) return;
    st = (st_in.len() > STR_MAX) ? st_in.substr(0, STR_MAX - 1) : st_in;
    pt = (pt_in.len() > PAT_MAX) ? pt_in.substr(0, PAT_MAX - 1) : pt_in;
    star = -1;
    for (int k = pt.len() - 1; k >= 0; k--) if (pt[k] == 8'h2A) star = k;
    for (int s = 0; s <= st.len(); s++) begin
      if (star < 0) begin
        if (match_seq(st, pt, 0, pt.len(), s, ic, pe)) begin
          m = 1'b1; idx = s % STR_MAX; ln = pe - s; return;
        end
      end else if (match_seq(st, pt, 0, star, s, ic, p)) begin
        for (int k = p; k <= st.len(); k++) begin
          if (match_seq(st, pt, star + 1, pt.len(), k, ic, pe)) begin
            m = 1'b1; idx = s % STR_MAX; ln = pe - s; return;
          end
        end
      end
    end
  endfunction

  // ---------------- stimulus helpers ---------------------------------------
  task automatic send_string(input string s);
    for (int k = 0; k < s.len(); k++) begin
      @(negedge clk);
      isstring = 1'b1;
      chardata = s[k];
    end
    @(negedge clk);
    isstring = 1'b0;
    chardata = '0;
  endtask

  // ignore_case is flipped after the first char: only that sample may count.
  task automatic drive_pattern(input string pat, input bit ic);
    for (int k = 0; k < pat.len(); k++) begin
      @(negedge clk);
      ispattern   = 1'b1;
      chardata    = pat[k];
      ignore_case = (k == 0) ? ic : !ic;
    end
    @(negedge clk);
    ispattern = 1'b0;
    chardata  = '0;
  endtask

  task automatic run_pattern(input string tag, input string pat, input bit ic,
                             input bit em, input int ei, input int el);
    int cyc;
    bit seen;
    drive_pattern(pat, ic);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, " busy_in_search"}, busy, 1);
      if (valid) seen = 1'b1;
    end
    txn++;
    $display("txn %0d %s pat=\"%s\" ic=%0d -> valid=%0d match=%0d index=%0d len=%0d (exp %0d/%0d/%0d) cycles=%0d",
             txn, tag, pat, ic, seen, match, match_index, match_len, em, ei, el, cyc);
    check({tag, " valid_seen"}, seen, 1);
    check({tag, " busy_at_valid"}, busy, 0);
    check({tag, " match"}, match, em);
    check({tag, " index"}, match_index, ei);
    check({tag, " len"}, match_len, el);
    @(negedge clk);
    check({tag, " valid_one_cycle"}, valid, 0);
  endtask

  // ---------------- test sequence ------------------------------------------
  vec_t vecs[$];
  string alpha, palpha, st, pt;
  int slen, plen, a, idx, ln, nvalid;
  bit ic, m;

  initial begin
    vecs.push_back('{"hello world", "wor",   1'b0, 1'b1, 6, 3});
    vecs.push_back('{"",            "^w.r",  1'b0, 1'b1, 6, 3});
    vecs.push_back('{"",            "d$",    1'b0, 1'b1, 10, 1});
    vecs.push_back('{"",            "xyz",   1'b0, 1'b0, 0, 0});
    vecs.push_back('{"",            "h*o w", 1'b0, 1'b1, 0, 7});
    vecs.push_back('{"",            "*ld",   1'b0, 1'b1, 0, 11});
    vecs.push_back('{"",            "o*o",   1'b0, 1'b1, 4, 4});
    vecs.push_back('{"",            "h*",    1'b0, 1'b1, 0, 1});
    vecs.push_back('{"",            "^",     1'b0, 1'b1, 0, 0});
    vecs.push_back('{"",            "WORLD", 1'b1, 1'b1, 6, 5});
    vecs.push_back('{"",            "WORLD", 1'b0, 1'b0, 0, 0});
    vecs.push_back('{"abcdefghij",  "abcdefghXYZ", 1'b0, 1'b1, 0, 8});
    vecs.push_back('{"abcdefghijklmnopqrstuvwxyz0123456789ABCD", "45", 1'b0, 1'b1, 30, 2});
    vecs.push_back('{"",            "67",    1'b0, 1'b0, 0, 0});
    vecs.push_back('{"",            "5$",    1'b0, 1'b1, 31, 1});

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset valid", valid, 0);
    check("reset match", match, 0);
    check("reset index", match_index, 0);
    check("reset len", match_len, 0);
    reset = 1'b0;
    @(negedge clk);

    // No string loaded yet: empty string never matches
    run_pattern("empty_string", "abc", 1'b0, 1'b0, 0, 0);

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].str.len() > 0) send_string(vecs[i].str);
      run_pattern($sformatf("vec%0d", i), vecs[i].pat, vecs[i].ic,
                  vecs[i].em, vecs[i].ei, vecs[i].el);
    end

    // Reset 5 cycles into SEARCH: no result, outputs cleared, string dropped
    send_string("hello world");
    drive_pattern("xyz", 1'b0);
    repeat (5) @(negedge clk);
    check("midreset busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("midreset busy", busy, 0);
    check("midreset valid", valid, 0);
    check("midreset match", match, 0);
    check("midreset index", match_index, 0);
    check("midreset len", match_len, 0);
    @(negedge clk);
    reset = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("midreset no_valid", nvalid, 0);
    run_pattern("after_reset_nostr", "hello", 1'b0, 1'b0, 0, 0);
    send_string("hello world");
    run_pattern("after_reset", "wor", 1'b0, 1'b1, 6, 3);

    // Randomised frames against the reference model
    alpha  = "abAB ";
    palpha = "abAB .^$";
    for (int t = 0; t < 30; t++) begin
      slen = $urandom_range(1, 20);
      st = "";
      for (int k = 0; k < slen; k++) begin
        st = {st, " "};
        st.putc(k, alpha[$urandom_range(0, alpha.len() - 1)]);
      end
      if ($urandom_range(0, 1) == 1) begin
        a    = $urandom_range(0, slen - 1);
        plen = $urandom_range(1, (slen - a < 4) ? slen - a : 4);
        pt   = st.substr(a, a + plen - 1);
        if ($urandom_range(0, 2) == 0) pt.putc($urandom_range(0, plen - 1), 8'h2E);
      end else begin
        plen = $urandom_range(1, 5);
        pt = "";
        for (int k = 0; k < plen; k++) begin
          pt = {pt, " "};
          pt.putc(k, palpha[$urandom_range(0, palpha.len() - 1)]);
        end
      end
      if ($urandom_range(0, 2) == 0) pt.putc($urandom_range(0, pt.len() - 1), 8'h2A);
      ic = 1'($urandom_range(0, 1));
      model(st, pt, ic, m, idx, ln);
      send_string(st);
      run_pattern($sformatf("rnd%0d str=\"%s\"", t, st), pt, ic, m, idx, ln);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sme_param.md
Name: sme_param

Overview:
Parametrised string-matching engine, the next generation of the team's fixed 32-char / 8-pattern-char matcher. It stores one string frame, then evaluates any number of following pattern frames against that string. Supported pattern elements are literal, '.', '^', '$' and one '*'. Each result reports match flag, leftmost start index and match length, with optional case-insensitive comparison. It sits between the character-stream front end and the result collector.

Parameters:
DW, 8, character width in bits
STR_MAX, 32, maximum string length in characters
PAT_MAX, 8, maximum pattern length in characters
IW, $clog2(STR_MAX), width of match_index
LW, $clog2(STR_MAX+1), width of match_len

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
chardata  input  DW  character of the current string/pattern frame
isstring  input  1  chardata is a string character
ispattern  input  1  chardata is a pattern character
ignore_case  input  1  sampled on the first pattern character; 1 = ASCII A-Z/a-z compare equal
busy  output  1  high from pattern-frame end until valid; inputs ignored while high
valid  output  1  one-cycle result strobe
match  output  1  pattern found in string
match_index  output  IW  start position of leftmost match
match_len  output  LW  string characters consumed by that match

Behaviour:
- Reset (async): FSM=IDLE; busy, valid, match, match_index and match_len all 0; string and pattern lengths 0.
- FSM states are IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
- IDLE/DONE -> LOAD_STR on isstring. IDLE/DONE -> LOAD_PAT on ispattern.
- LOAD_STR -> LOAD_PAT when ispattern is high; otherwise LOAD_STR -> IDLE when isstring drops.
- LOAD_PAT -> SEARCH on the first cycle with ispattern low.
- SEARCH -> DONE when the search resolves. DONE lasts 1 cycle, then -> IDLE.
- isstring and ispattern are never high together. If they are, isstring wins.
- A new string frame (isstring rising from IDLE/DONE) clears the string length and rewrites from index 0. The previous string stays valid for later pattern frames until then.
- Characters beyond STR_MAX (string) or PAT_MAX (pattern) are dropped; the length saturates.
- An empty string or empty pattern gives match=0.
- Pattern semantics, evaluated left to right:
  - literal: equal char, case-folded if ignore_case=1.
  - '.' (0x2E): any one char.
  - '^' (0x5E): zero-width; true iff pos==0 or str[pos-1]==0x20.
  - '$' (0x24): zero-width; true iff pos==len or str[pos]==0x20.
  - '*' (0x2A): any run of 0 or more chars, shortest first (non-greedy).
  - At most one '*' per pattern is supported; the result for two or more is unspecified and is not verified.
- Search: candidate start s = 0..len, tried in order.
  - One element compare per cycle.
  - On a mismatch with no active '*': restart at s+1.
  - On a mismatch after '*': extend the star span by 1 and retry the post-star suffix. The search fails at s when the span reaches the string end.
  - The first success fixes match_index = s and match_len = consumed chars; anchors consume 0.
- A leading '*' matches at s=0 whenever the remaining pattern matches anywhere.
- Latency from the pattern-end cycle to valid is at most (STR_MAX+1)*(PAT_MAX+1)*(STR_MAX+1)+4 cycles. Patterns without '*' take at most (STR_MAX+1)*(PAT_MAX+1)+4 cycles.
- valid rises in the DONE cycle.
- match, match_index and match_len update in the same cycle as valid and hold until the next valid. On no match they are 0/0/0.
- busy drops in the same cycle valid rises. Pattern input is accepted starting with the cycle after valid.
- Back-to-back frames: a pattern frame may start the cycle after valid. The string is retained.
- Reset mid-SEARCH: abort; no valid is produced; all outputs return to 0 and the stored string is discarded.

Test Plan:
- String "hello world" (11 chars), pattern "wor", ignore_case=0 -> valid 1 cycle, match=1, index=6, len=3.
- Same string; patterns "^w.r", then "d$", then "xyz", back-to-back -> (1,6,3), (1,10,1), (0,0,0); string loaded once.
- Same string; pattern "h*o w" -> match=1, index=0, len=7 (non-greedy span "ell"). Pattern "*ld" -> match=1, index=0, len=11.
- Same string; pattern "WORLD" with ignore_case=1 -> (1,6,5). Same pattern with ignore_case=0 -> (0,0,0).
- 40-char string, STR_MAX=32, pattern = chars 30..31 -> match=1, index=30, len=2; chars 32..39 ignored.
- Assert reset 5 cycles into SEARCH -> no valid; outputs are 0; the next string+pattern frame works normally.
